// File: rtl/noise_filter_pkg.sv
// Shared types and constants for the noise filter core and its per-channel lanes.
package noise_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_EDGE  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int KERNEL_SIZE = 9;
    localparam int GAUSS_ROUND = 8;
    localparam int GAUSS_SHIFT = 4;

endpackage

// File: rtl/noise_filter_lane.sv
// Single-channel 3x3 filter arithmetic: S1 partial sums, S2 sums/magnitude,
// S3 normalise and saturate. All stages shift only when en is high.
module noise_filter_lane
    import noise_filter_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [KERNEL_SIZE*PIX_W-1:0] win,
    input  mode_e                        s2_mode,
    output logic [PIX_W-1:0]             pix,
    output logic                         sat
);

    localparam int GW      = PIX_W + 4;
    localparam int EW      = PIX_W + 3;
    localparam int PIX_MAX = (1 << PIX_W) - 1;

    logic [GW-1:0] g_in [KERNEL_SIZE];
    logic [EW-1:0] e_in [KERNEL_SIZE];

    logic [GW-1:0]    s1_g_r0, s1_g_r1, s1_g_r2;
    logic [EW-1:0]    s1_gx_pos, s1_gx_neg, s1_gy_pos, s1_gy_neg;
    logic [PIX_W-1:0] s1_centre;

    logic [GW-1:0]        s2_gsum;
    logic [EW-1:0]        s2_mag;
    logic [PIX_W-1:0]     s2_centre;
    logic signed [EW-1:0] gx, gy;
    logic [EW-1:0]        ax, ay;

    logic [PIX_W-1:0] s3_pix_next;
    logic             s3_sat_next;

    always_comb begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            g_in[k] = GW'(win[k*PIX_W +: PIX_W]);
            e_in[k] = EW'(win[k*PIX_W +: PIX_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_g_r0   <= '0;
            s1_g_r1   <= '0;
            s1_g_r2   <= '0;
            s1_gx_pos <= '0;
            s1_gx_neg <= '0;
            s1_gy_pos <= '0;
            s1_gy_neg <= '0;
            s1_centre <= '0;
        end else if (en) begin
            s1_g_r0   <= g_in[0] + (g_in[1] << 1) + g_in[2];
            s1_g_r1   <= (g_in[3] << 1) + (g_in[4] << 2) + (g_in[5] << 1);
            s1_g_r2   <= g_in[6] + (g_in[7] << 1) + g_in[8];
            s1_gx_pos <= e_in[2] + (e_in[5] << 1) + e_in[8];
            s1_gx_neg <= e_in[0] + (e_in[3] << 1) + e_in[6];
            s1_gy_pos <= e_in[6] + (e_in[7] << 1) + e_in[8];
            s1_gy_neg <= e_in[0] + (e_in[1] << 1) + e_in[2];
            s1_centre <= win[4*PIX_W +: PIX_W];
        end
    end

    // Partial sums are at most 4*(2^PIX_W-1), so the differences fit signed EW bits.
    always_comb begin
        gx = signed'(s1_gx_pos - s1_gx_neg);
        gy = signed'(s1_gy_pos - s1_gy_neg);
        ax = gx[EW-1] ? EW'(-gx) : EW'(gx);
        ay = gy[EW-1] ? EW'(-gy) : EW'(gy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_gsum   <= '0;
            s2_mag    <= '0;
            s2_centre <= '0;
        end else if (en) begin
            s2_gsum   <= s1_g_r0 + s1_g_r1 + s1_g_r2;
            s2_mag    <= ax + ay;
            s2_centre <= s1_centre;
        end
    end

    always_comb begin
        s3_pix_next = s2_centre;
        s3_sat_next = 1'b0;
        case (s2_mode)
            MODE_GAUSS: s3_pix_next = PIX_W'((s2_gsum + GW'(GAUSS_ROUND)) >> GAUSS_SHIFT);
            MODE_EDGE: begin
                s3_sat_next = (s2_mag > EW'(PIX_MAX));
                s3_pix_next = s3_sat_next ? '1 : PIX_W'(s2_mag);
            end
            default: s3_pix_next = s2_centre;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix <= '0;
            sat <= 1'b0;
        end else if (en) begin
            pix <= s3_pix_next;
            sat <= s3_sat_next;
        end
    end

endmodule

// File: rtl/noise_filter_core.sv
// Multi-channel 3x3 noise filter: valid/mode pipeline, per-channel lanes and optional
// output statistics enabled by the NOISE_FILTER_STATS_EN macro.
module noise_filter_core
    import noise_filter_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PIX_W  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_CH*KERNEL_SIZE*PIX_W-1:0]   win_data,
    input  logic [1:0]                            mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_CH*PIX_W-1:0]               pixel_data,
    output logic [31:0]                           stat_pix_count,
    output logic [31:0]                           stat_sat_count
);

    logic        advance;
    logic        valid_s1, valid_s2, valid_s3;
    mode_e       mode_s1, mode_s2, mode_s3;
    logic [NUM_CH-1:0] sat_vec;

    // The whole pipeline freezes as one unit whenever the output is held.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            valid_s3 <= 1'b0;
            mode_s1  <= MODE_PASS;
            mode_s2  <= MODE_PASS;
            mode_s3  <= MODE_PASS;
        end else if (advance) begin
            valid_s1 <= in_valid;
            valid_s2 <= valid_s1;
            valid_s3 <= valid_s2;
            mode_s1  <= mode_e'(mode);
            mode_s2  <= mode_s1;
            mode_s3  <= mode_s2;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        noise_filter_lane #(.PIX_W(PIX_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .win     (win_data[c*KERNEL_SIZE*PIX_W +: KERNEL_SIZE*PIX_W]),
            .s2_mode (mode_s2),
            .pix     (pixel_data[(NUM_CH-1-c)*PIX_W +: PIX_W]),
            .sat     (sat_vec[c])
        );
    end

`ifdef NOISE_FILTER_STATS_EN
    logic [31:0] pix_cnt, sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            sat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            pix_cnt <= pix_cnt + 32'd1;
            if (mode_s3 == MODE_EDGE && |sat_vec) begin
                sat_cnt <= sat_cnt + 32'd1;
            end
        end
    end

    assign stat_pix_count = pix_cnt;
    assign stat_sat_count = sat_cnt;
`else
    logic unused_stats;
    assign unused_stats   = ^{sat_vec, mode_s3};
    assign stat_pix_count = '0;
    assign stat_sat_count = '0;
`endif

endmodule

// File: tb/tb_noise_filter_core.sv
// Scoreboard bench for noise_filter_core: directed windows, stalled and mixed-mode
// streams, and mid-stream reset; stats expectations follow NOISE_FILTER_STATS_EN.
module tb_noise_filter_core;
    import noise_filter_pkg::*;

    localparam int NUM_CH = 3;
    localparam int PIX_W  = 8;
    localparam int WIN_W  = NUM_CH * 9 * PIX_W;
    localparam int OUT_W  = NUM_CH * PIX_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] win_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] pixel_data;
    logic [31:0]      stat_pix_count;
    logic [31:0]      stat_sat_count;

    typedef struct {
        logic [OUT_W-1:0] pix;
        bit               sat;
        bit               lat;
        int               acc;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               tcyc = 0;
    bit               stall_on = 0;
    logic [31:0]      exp_pix_cnt = '0;
    logic [31:0]      exp_sat_cnt = '0;
    bit               hold_active = 0;
    logic [OUT_W-1:0] hold_pix;

    noise_filter_core #(.NUM_CH(NUM_CH), .PIX_W(PIX_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .win_data       (win_data),
        .mode           (mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pixel_data     (pixel_data),
        .stat_pix_count (stat_pix_count),
        .stat_sat_count (stat_sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] fill_win(input int px[9]);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 9; k++)
                w[c*9*PIX_W + k*PIX_W +: PIX_W] = PIX_W'(px[k]);
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] w;
        for (int i = 0; i < NUM_CH * 9; i++)
            w[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
        return w;
    endfunction

    // Reference arithmetic written directly from the kernel definitions.
    task automatic model(input logic [WIN_W-1:0] w, input logic [1:0] m,
                         output logic [OUT_W-1:0] px, output bit sat);
        int p[9];
        int r, gx, gy;
        px  = '0;
        sat = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 9; k++) p[k] = int'(w[c*9*PIX_W + k*PIX_W +: PIX_W]);
            if (m == 2'd1) begin
                r = (p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8] + 8) / 16;
            end else if (m == 2'd2) begin
                gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
                gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
                r  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (r > 255) begin
                    r   = 255;
                    sat = 1;
                end
            end else begin
                r = p[4];
            end
            px[(NUM_CH-1-c)*PIX_W +: PIX_W] = PIX_W'(r);
        end
    endtask

    task automatic applyStimulus(input logic [WIN_W-1:0] w, input logic [1:0] m,
                                 input logic [OUT_W-1:0] expx, input bit sat, input bit lat);
        exp_t e;
        int   tries;
        bit   done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            win_data  = w;
            mode      = m;
            out_ready = !(stall_on && tcyc >= 4 && tcyc <= 8);
            tcyc++;
            @(negedge clk);
            if (in_ready) begin
                e.pix = expx;
                e.sat = sat;
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
                done = 1;
            end else begin
                tries++;
                if (tries > 50) begin
                    cmp("accept_timeout", 64'(tries), 64'd0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle_step();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = !(stall_on && tcyc >= 4 && tcyc <= 8);
        tcyc++;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            idle_step();
            n++;
        end
        idle_step();
        cmp("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic checkOutput();
        exp_t e;
        cmp("output_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp("pixel_data", 64'(pixel_data), 64'(e.pix));
            if (e.lat) cmp("latency", 64'(cyc - e.acc), 64'd3);
            cmp("stat_pix_count", 64'(stat_pix_count), 64'(exp_pix_cnt));
            cmp("stat_sat_count", 64'(stat_sat_count), 64'(exp_sat_cnt));
`ifdef NOISE_FILTER_STATS_EN
            exp_pix_cnt = exp_pix_cnt + 32'd1;
            if (e.sat) exp_sat_cnt = exp_sat_cnt + 32'd1;
`endif
        end
    endtask

    // Output monitor: scoreboard pops on transfers and stability checks while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_active = 0;
        end else begin
            if (hold_active) begin
                cmp("stall_out_valid", 64'(out_valid), 64'd1);
                cmp("stall_pixel_hold", 64'(pixel_data), 64'(hold_pix));
            end
            if (out_valid && !out_ready) begin
                cmp("stall_in_ready", 64'(in_ready), 64'd0);
                hold_active = 1;
                hold_pix    = pixel_data;
            end else begin
                hold_active = 0;
            end
            if (out_valid && out_ready) checkOutput();
        end
    end

    initial begin
        logic [WIN_W-1:0] w;
        logic [OUT_W-1:0] px;
        logic [1:0]       m;
        bit               s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        win_data  = '0;
        mode      = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp("reset_in_ready", 64'(in_ready), 64'd1);
        cmp("reset_out_valid", 64'(out_valid), 64'd0);
        cmp("reset_pixel_data", 64'(pixel_data), 64'd0);
        cmp("reset_stat_pix", 64'(stat_pix_count), 64'd0);
        cmp("reset_stat_sat", 64'(stat_sat_count), 64'd0);

        $display("[TB] directed windows");
        applyStimulus(fill_win('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 2'd1, 24'h646464, 0, 1);
        wait_drain();
        applyStimulus(fill_win('{0, 2, 0, 2, 2, 2, 0, 2, 0}), 2'd1, 24'h020202, 0, 1);
        wait_drain();
        applyStimulus(fill_win('{0, 128, 255, 0, 128, 255, 0, 128, 255}), 2'd2, 24'hFFFFFF, 1, 1);
        wait_drain();
        applyStimulus(fill_win('{77, 77, 77, 77, 77, 77, 77, 77, 77}), 2'd2, 24'h000000, 0, 1);
        applyStimulus(fill_win('{1, 2, 3, 4, 201, 6, 7, 8, 9}), 2'd3, 24'hC9C9C9, 0, 1);
        wait_drain();

        $display("[TB] stalled stream of 6 windows");
        stall_on = 1;
        tcyc     = 0;
        for (int i = 0; i < 6; i++) begin
            w = rand_win();
            m = 2'($urandom_range(0, 3));
            model(w, m, px, s);
            applyStimulus(w, m, px, s, 0);
        end
        wait_drain();
        stall_on = 0;

        $display("[TB] alternating modes");
        for (int i = 0; i < 9; i++) begin
            w = rand_win();
            m = 2'(i % 3);
            model(w, m, px, s);
            applyStimulus(w, m, px, s, 1);
        end
        wait_drain();
        cmp("stat_pix_before_reset", 64'(stat_pix_count), 64'(exp_pix_cnt));

        $display("[TB] reset with windows in flight");
        for (int i = 0; i < 3; i++) begin
            w = rand_win();
            applyStimulus(w, 2'd0, '0, 0, 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        exp_pix_cnt = '0;
        exp_sat_cnt = '0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        cmp("midrst_out_valid", 64'(out_valid), 64'd0);
        cmp("midrst_pixel_data", 64'(pixel_data), 64'd0);
        cmp("midrst_stat_pix", 64'(stat_pix_count), 64'd0);
        cmp("midrst_stat_sat", 64'(stat_sat_count), 64'd0);
        cmp("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            idle_step();
            cmp("midrst_quiet", 64'(out_valid), 64'd0);
        end

        applyStimulus(fill_win('{9, 9, 9, 9, 90, 9, 9, 9, 9}), 2'd0, 24'h5A5A5A, 0, 1);
        wait_drain();
        cmp("final_stat_pix", 64'(stat_pix_count), 64'(exp_pix_cnt));
        cmp("final_stat_sat", 64'(stat_sat_count), 64'(exp_sat_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noise_filter_core.md
NOISE_FILTER_CORE -- requirements
Module: noise_filter_core

Interface
REQ-001 Parameter NUM_CH, default 3, number of colour channels processed in parallel.
REQ-002 Parameter PIX_W, default 8, bits per pixel sample.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  window present on win_data.
REQ-006 in_ready  out  1  core accepts window this cycle.
REQ-007 win_data  in  NUM_CH*9*PIX_W  channel c at [c*9*PIX_W +: 9*PIX_W]; within channel, pixel k (0..8, row-major, p4 = centre) at [k*PIX_W +: PIX_W].
REQ-008 mode  in  2  per-window filter select, sampled with the window: 0 PASS, 1 GAUSS, 2 EDGE, 3 reserved (behaves as PASS).
REQ-009 out_valid  out  1  pixel_data valid.
REQ-010 out_ready  in  1  downstream accepts pixel_data.
REQ-011 pixel_data  out  NUM_CH*PIX_W  channel c at [(NUM_CH-1-c)*PIX_W +: PIX_W] (channel 0 most significant).
REQ-012 stat_pix_count  out  32, stat_sat_count  out  32  statistics (see Configuration).

Function
REQ-013 Input handshake: window accepted when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 Three-stage pipeline (S1 products/partial sums, S2 sums, S3 normalise/saturate); each stage holds a valid bit and its mode.
REQ-015 advance = !out_valid || out_ready; in_ready = advance; all stages shift together only when advance=1.
REQ-016 Latency exactly 3 cycles from acceptance to out_valid with no stall; full throughput of one window per cycle.
REQ-017 While advance=0, pixel_data and out_valid held stable; no window lost or duplicated.
REQ-018 PASS: output = p4 per channel.
REQ-019 GAUSS: kernel 1 2 1 / 2 4 2 / 1 2 1, sum in PIX_W+4 bits, output = (sum + 8) >> 4; never overflows.
REQ-020 EDGE: Gx = (p2+2p5+p8)-(p0+2p3+p6), Gy = (p6+2p7+p8)-(p0+2p1+p2), signed PIX_W+3 bits; mag = |Gx|+|Gy|; output = min(mag, 2^PIX_W-1).
REQ-021 Mode is carried per window; consecutive windows with different modes are each filtered by their own mode.
REQ-022 Channels independent; identical arithmetic per channel.

Reset
REQ-023 On rst: all stage valid bits 0, out_valid 0, pixel_data 0, statistics 0; in_ready = 1 in the cycle after reset.
REQ-024 rst mid-stream discards all in-flight windows; no out_valid until a new window propagates 3 cycles.

Configuration
REQ-025 Macro NOISE_FILTER_STATS_EN: when defined, stat_pix_count increments on every output transfer and stat_sat_count increments once per transferred EDGE pixel in which any channel saturated; both wrap modulo 2^32.
REQ-026 Without NOISE_FILTER_STATS_EN: both stat outputs tied to 0, no counter logic; datapath unchanged.

Structure
REQ-027 Package noise_filter_pkg holds the mode enum (PASS, GAUSS, EDGE, RSVD), GAUSS rounding constant, and a kernel-size constant (9).
REQ-028 One sub-module noise_filter_lane: single-channel 3-stage arithmetic with stall enable; instantiated NUM_CH times via generate; control (valid/advance/stats) in noise_filter_core.

Verification
REQ-029 GAUSS, all pixels 100, all channels -> pixel_data 0x646464 three cycles after acceptance.
REQ-030 GAUSS, p4=2, others 0 plus p1=p3=p5=p7=2 (sum 24) -> channel output 2 (rounding check).
REQ-031 EDGE, column 0 = 0, column 2 = 255, column 1 = 128 -> output 255 per channel, stat_sat_count +1 with macro; flat window of 77 -> 0.
REQ-032 Stream 6 windows back-to-back, out_ready low cycles 4-8 -> in_ready low while stalled, all 6 outputs appear in order, unchanged during stall.
REQ-033 Alternate modes PASS/GAUSS/EDGE every cycle -> each output matches its own mode's model.
REQ-034 Assert rst with 3 windows in flight -> out_valid 0 next cycle, none of the 3 ever emitted, counters 0.
